// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
//   Shared types and constants for the run/halt/single-step controller.
//   - state_t        : controller state encoding (HALT is the all-zero code so
//                      a cleared register reads as "not running")
//   - CYCLE_COUNT_W  : width of the optional enabled-cycle counter
//   - stateEnables() : decode of the datapath clock enable from a state value
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int CYCLE_COUNT_W = 16;

  // The datapath runs in every state except HALT.
  function automatic logic stateEnables(input state_t s);
    return (s != ST_HALT);
  endfunction

endpackage

// File: rtl/run_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// debounce
//   Two-flop synchroniser plus stability counter for the raw push button.
//   A level change is accepted only after the synchronised level has differed
//   from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept a change
//                     (minimum 2)
// Ports
//   i_clk     in   system clock
//   i_reset   in   synchronous active-high reset
//   i_button  in   raw asynchronous button, active high
//   o_level   out  accepted (debounced) button level
//   o_press   out  one-cycle pulse, high in the cycle before o_level rises
// -----------------------------------------------------------------------------
module debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_button,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  logic differ;
  logic settle;

  // settle is decoded from registers only, so o_press has no path from the pin.
  assign differ = (sync2 != stable);
  assign settle = differ && (cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= i_button;
      sync2 <= sync1;
      if (!differ) begin
        // Any agreement restarts the stability window.
        cnt <= '0;
      end else if (settle) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_level = stable;
  assign o_press = settle & sync2;

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
//   Run/halt/single-step controller for the 8-bit datapath. Produces a
//   synchronous clock enable for every datapath register and sequences the
//   machine between RUN, HALT and STEP from the HLT microinstruction, the
//   debounced board button and the step-mode switch.
//
//   Handshake/qualification: i_ctrlHlt and i_instrDone are only meaningful in
//   cycles where o_clkEn is high; while halted they are ignored. The button
//   press is a single-cycle pulse taken from the debouncer.
//
//   Build option: define RUN_CTRL_CYCLE_COUNT_EN to build the 16-bit enabled
//   cycle counter on o_cycleCount; otherwise o_cycleCount is tied to zero.
//
// Parameters
//   DEBOUNCE_CYCLES : button stability window in cycles (minimum 2)
// Ports
//   i_clk         in   system clock
//   i_reset       in   synchronous active-high reset
//   i_button      in   raw asynchronous push button, active high
//   i_modeStep    in   0 = run mode, 1 = step mode (quasi-static)
//   i_ctrlHlt     in   HLT microinstruction flag
//   i_instrDone   in   last microstep of the current instruction
//   o_clkEn       out  datapath clock enable (state != HALT)
//   o_halted      out  state is HALT
//   o_stepping    out  state is STEP
//   o_cycleCount  out  count of enabled cycles (zero when not built)
//
//   The FSM state is fully visible on o_clkEn/o_halted/o_stepping.
// -----------------------------------------------------------------------------
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_button,
  input  logic                     i_modeStep,
  input  logic                     i_ctrlHlt,
  input  logic                     i_instrDone,
  output logic                     o_clkEn,
  output logic                     o_halted,
  output logic                     o_stepping,
  output logic [CYCLE_COUNT_W-1:0] o_cycleCount
);

  if (DEBOUNCE_CYCLES < 2) begin : g_badParam
    $error("run_ctrl: DEBOUNCE_CYCLES must be at least 2");
  end

  state_t state;
  state_t nextState;

  logic press;
  logic btnLevel;
  logic hltQ;
  logic doneQ;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_button(i_button),
    .o_level (btnLevel),
    .o_press (press)
  );

  // Control flags only count while the datapath is actually clocked.
  assign hltQ  = i_ctrlHlt   & o_clkEn;
  assign doneQ = i_instrDone & o_clkEn;

  // Priority: HLT > instrDone > press.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_RUN: begin
        if (hltQ) begin
          nextState = ST_HALT;
        end else if (doneQ && i_modeStep) begin
          nextState = ST_HALT;
        end else if (press) begin
          nextState = ST_HALT;
        end
      end
      ST_STEP: begin
        if (hltQ || doneQ) begin
          nextState = ST_HALT;
        end
      end
      ST_HALT: begin
        if (press) begin
          nextState = i_modeStep ? ST_STEP : ST_RUN;
        end
      end
      default: nextState = ST_HALT;
    endcase
  end

  // Outputs are registered alongside the state so they carry no input path.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= i_modeStep ? ST_HALT : ST_RUN;
      o_clkEn    <= ~i_modeStep;
      o_halted   <= i_modeStep;
      o_stepping <= 1'b0;
    end else begin
      state      <= nextState;
      o_clkEn    <= stateEnables(nextState);
      o_halted   <= (nextState == ST_HALT);
      o_stepping <= (nextState == ST_STEP);
    end
  end

`ifdef RUN_CTRL_CYCLE_COUNT_EN
  logic [CYCLE_COUNT_W-1:0] cycleCount;

  // Wraps naturally from all-ones to zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycleCount <= '0;
    end else if (o_clkEn) begin
      cycleCount <= cycleCount + 1'b1;
    end
  end

  assign o_cycleCount = cycleCount;
`else
  assign o_cycleCount = '0;
`endif

  // A press pulse always leaves the accepted button level high.
  a_pressLevel: assert property (@(posedge i_clk) disable iff (i_reset)
    press |=> btnLevel);

  // The registered enable must always agree with the state register.
  a_enMatchesState: assert property (@(posedge i_clk)
    o_clkEn == stateEnables(state));

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
//   Directed scenarios for run_ctrl with DEBOUNCE_CYCLES = 4. The driver pushes
//   expected responses into exp_q after each edge; the monitor pops and compares
//   on the falling edge. Entry layout: {kind[1:0], value[15:0]}
//     kind 0 : {clkEn, halted, stepping} in value[2:0]
//     kind 1 : o_cycleCount
//     kind 2 : running count of debouncer press pulses
//     kind 3 : debouncer counter value
// -----------------------------------------------------------------------------
module tb_run_ctrl;

  localparam int W = 18;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_button = 1'b0;
  logic        i_modeStep = 1'b0;
  logic        i_ctrlHlt = 1'b0;
  logic        i_instrDone = 1'b0;
  logic        o_clkEn;
  logic        o_halted;
  logic        o_stepping;
  logic [15:0] o_cycleCount;

  always #5 i_clk = ~i_clk;

  run_ctrl #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_button    (i_button),
    .i_modeStep  (i_modeStep),
    .i_ctrlHlt   (i_ctrlHlt),
    .i_instrDone (i_instrDone),
    .o_clkEn     (o_clkEn),
    .o_halted    (o_halted),
    .o_stepping  (o_stepping),
    .o_cycleCount(o_cycleCount)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  int           pressCount = 0;

  function automatic int expCnt(input int v);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    return v & 16'hFFFF;
`else
    return 0;
`endif
  endfunction

  task automatic pushExp(input string name, input logic [1:0] kind, input logic [15:0] val);
    exp_q.push_back({kind, val});
    name_q.push_back(name);
  endtask

  task automatic expState(input string name, input logic en, input logic h, input logic s);
    pushExp(name, 2'd0, {13'd0, en, h, s});
  endtask

  task automatic expCount(input string name, input int v);
    pushExp(name, 2'd1, 16'(expCnt(v)));
  endtask

  always @(negedge i_clk) begin : monitor
    logic [W-1:0] e;
    string        nm;
    logic [15:0]  act;
    if (dut.u_debounce.o_press) pressCount++;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e[17:16])
        2'd0:    act = {13'd0, o_clkEn, o_halted, o_stepping};
        2'd1:    act = o_cycleCount;
        2'd2:    act = 16'(pressCount);
        default: act = 16'(dut.u_debounce.cnt);
      endcase
      checks++;
      if (act !== e[15:0]) begin
        errors++;
        $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, e[15:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  localparam logic RUN_EN = 1'b1;

  initial begin : driver
    int base;
    int wrapN;

    // Reset in run mode
    i_reset = 1'b1; i_modeStep = 1'b0;
    steps(2);
    expState("reset_run", 1'b1, 1'b0, 1'b0);
    expCount("reset_count", 0);
    i_reset = 1'b0;

    // RUN counts, then HLT halts on the next cycle
    steps(3);
    expState("run_free", RUN_EN, 1'b0, 1'b0);
    expCount("run_count3", 3);
    i_ctrlHlt = 1'b1;
    step();
    i_ctrlHlt = 1'b0;
    expState("hlt_halts", 1'b0, 1'b1, 1'b0);
    expCount("hlt_count", 4);
    steps(3);
    expState("halt_stays", 1'b0, 1'b1, 1'b0);
    expCount("halt_count_frozen", 4);

    // Run-mode press from HALT: RUN exactly at edge 6
    i_button = 1'b1;
    steps(5);
    expState("press_edge5_halt", 1'b0, 1'b1, 1'b0);
    step();
    expState("press_edge6_run", 1'b1, 1'b0, 1'b0);
    expCount("press_count", 4);
    steps(2);
    i_button = 1'b0;
    steps(8);
    expState("release_run", 1'b1, 1'b0, 1'b0);
    expCount("release_count", 14);
    i_button = 1'b1;
    steps(5);
    expState("pause_edge5_run", 1'b1, 1'b0, 1'b0);
    step();
    expState("pause_edge6_halt", 1'b0, 1'b1, 1'b0);
    expCount("pause_count", 20);
    i_button = 1'b0;
    steps(8);

    // Step mode: three enabled cycles per press
    i_modeStep = 1'b1;
    i_button = 1'b1;
    steps(5);
    expState("step_edge5_halt", 1'b0, 1'b1, 1'b0);
    step();
    expState("step_enter", 1'b1, 1'b0, 1'b1);
    step();
    expState("step_cyc2", 1'b1, 1'b0, 1'b1);
    step();
    i_instrDone = 1'b1;
    step();
    i_instrDone = 1'b0;
    expState("step_done_halt", 1'b0, 1'b1, 1'b0);
    expCount("step_count3", 23);
    i_button = 1'b0;
    steps(8);
    expState("step_release_halt", 1'b0, 1'b1, 1'b0);

    // Press during STEP is ignored
    i_button = 1'b1;
    steps(6);
    expState("step2_enter", 1'b1, 1'b0, 1'b1);
    steps(2);
    i_button = 1'b0;
    steps(8);
    base = pressCount;
    i_button = 1'b1;
    steps(6);
    expState("step_press_ignored", 1'b1, 1'b0, 1'b1);
    pushExp("step_press_seen", 2'd2, 16'(base + 1));
    expCount("step_count_long", 39);
    i_instrDone = 1'b1;
    step();
    i_instrDone = 1'b0;
    expState("step2_done_halt", 1'b0, 1'b1, 1'b0);
    expCount("step2_count", 40);
    i_button = 1'b0;
    steps(8);

    // Glitch of 3 cycles gives no press
    i_modeStep = 1'b0;
    base = pressCount;
    i_button = 1'b1;
    steps(3);
    i_button = 1'b0;
    steps(8);
    expState("glitch_no_change", 1'b0, 1'b1, 1'b0);
    pushExp("glitch_no_press", 2'd2, 16'(base));

    // HLT and press in the same cycle: stays halted
    i_button = 1'b1;
    steps(6);
    expState("resume_run", 1'b1, 1'b0, 1'b0);
    steps(2);
    i_button = 1'b0;
    steps(8);
    i_button = 1'b1;
    steps(5);
    expState("coinc_pre_run", 1'b1, 1'b0, 1'b0);
    i_ctrlHlt = 1'b1;
    step();
    i_ctrlHlt = 1'b0;
    expState("coinc_halt", 1'b0, 1'b1, 1'b0);
    steps(3);
    expState("coinc_still_halt", 1'b0, 1'b1, 1'b0);

    // Reset in STEP while a press is being debounced
    i_modeStep = 1'b1;
    i_button = 1'b0;
    steps(8);
    i_button = 1'b1;
    steps(6);
    expState("rst_pre_step", 1'b1, 1'b0, 1'b1);
    i_button = 1'b0;
    steps(8);
    i_button = 1'b1;
    steps(4);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    expState("rst_step_halt", 1'b0, 1'b1, 1'b0);
    expCount("rst_count_clear", 0);
    pushExp("rst_cnt_clear", 2'd3, 16'd0);
    steps(5);
    expState("rst_press_lost", 1'b0, 1'b1, 1'b0);
    step();
    expState("rst_press_fresh", 1'b1, 1'b0, 1'b1);

    // Counter wrap (full length only when the counter is built)
    i_button = 1'b0;
    i_modeStep = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    expState("wrap_reset_run", 1'b1, 1'b0, 1'b0);
    expCount("wrap_start", 0);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    wrapN = 65535;
`else
    wrapN = 20;
`endif
    steps(wrapN);
    expCount("wrap_top", wrapN);
    step();
    expCount("wrap_over", wrapN + 1);

    // Drain and report
    steps(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
